// File: rtl/expand_kernal_sequencer.sv
// Kernel-RAM read sequencer for the expand convolution stage: walks the shared
// kernel address over limit words per layer word, then drains the datapath pipe.
module expand_kernal_sequencer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [6:0]  one_exp_ker_addr_limit_i,
    input  logic [15:0] layer_word_count_i,
    input  logic        ker_req_i,
    output logic        ker_ready_o,
    output logic [6:0]  ker_rd_addr_o,
    output logic        ker_rd_en_o,
    output logic        layer_last_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'd2;

    state_t      state;
    logic [6:0]  addr;
    logic [15:0] word_cnt;
    logic [6:0]  limit_q;
    logic [15:0] count_q;
    logic [1:0]  drain_cnt;

    logic        addr_wrap;
    logic        last_word;
    logic        rd_fire;

    // limit_q and count_q are non-zero whenever the FSM is in RUN.
    assign addr_wrap = (addr == limit_q - 7'd1);
    assign last_word = (word_cnt == count_q - 16'd1);
    assign rd_fire   = ker_req_i && (state == S_RUN);

    assign ker_ready_o   = (state == S_RUN);
    assign ker_rd_en_o   = rd_fire;
    assign ker_rd_addr_o = addr;
    assign layer_last_o  = (state == S_RUN) && last_word;
    assign busy_o        = (state == S_RUN) || (state == S_DRAIN);
    assign done_o        = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            addr      <= 7'd0;
            word_cnt  <= 16'd0;
            limit_q   <= 7'd0;
            count_q   <= 16'd0;
            drain_cnt <= 2'd0;
        end else if (start_i) begin
            limit_q   <= one_exp_ker_addr_limit_i;
            count_q   <= layer_word_count_i;
            addr      <= 7'd0;
            word_cnt  <= 16'd0;
            drain_cnt <= 2'd0;
            if (one_exp_ker_addr_limit_i == 7'd0 || layer_word_count_i == 16'd0)
                state <= S_DONE;
            else
                state <= S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (ker_req_i) begin
                        if (addr_wrap) begin
                            addr     <= 7'd0;
                            word_cnt <= word_cnt + 16'd1;
                            if (last_word) begin
                                state     <= S_DRAIN;
                                drain_cnt <= 2'd0;
                            end
                        end else begin
                            addr <= addr + 7'd1;
                        end
                    end
                end
                // Three drain cycles cover the datapath's two-stage data/flag pipe.
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST)
                        state <= S_DONE;
                    else
                        drain_cnt <= drain_cnt + 2'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_expand_kernal_sequencer.sv
// Self-checking bench for expand_kernal_sequencer: linear read-index model,
// per-cycle output comparison, directed layers and randomized traffic.
module tb_expand_kernal_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [6:0]  one_exp_ker_addr_limit_i = 7'd0;
    logic [15:0] layer_word_count_i = 16'd0;
    logic        ker_req_i = 1'b0;
    logic        ker_ready_o;
    logic [6:0]  ker_rd_addr_o;
    logic        ker_rd_en_o;
    logic        layer_last_o;
    logic        busy_o;
    logic        done_o;

    expand_kernal_sequencer dut (
        .clk_i                    (clk_i),
        .rst_n_i                  (rst_n_i),
        .start_i                  (start_i),
        .one_exp_ker_addr_limit_i (one_exp_ker_addr_limit_i),
        .layer_word_count_i       (layer_word_count_i),
        .ker_req_i                (ker_req_i),
        .ker_ready_o              (ker_ready_o),
        .ker_rd_addr_o            (ker_rd_addr_o),
        .ker_rd_en_o              (ker_rd_en_o),
        .layer_last_o             (layer_last_o),
        .busy_o                   (busy_o),
        .done_o                   (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a layer is limit*count reads numbered 0..total-1; the address is
    // the read index mod limit and the layer word is index div limit. After the
    // last read come three busy cycles, then one done cycle.
    bit m_run = 1'b0;
    int m_idx = 0;
    int m_total = 0;
    int m_lim = 0;
    int m_cnt = 0;
    int m_tail = -1;   // -1 none, 0..2 drain cycles, 3 done cycle

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_run = 1'b0; m_idx = 0; m_total = 0; m_lim = 0; m_cnt = 0; m_tail = -1;
        end else if (start_i) begin
            m_lim   = int'(one_exp_ker_addr_limit_i);
            m_cnt   = int'(layer_word_count_i);
            m_total = m_lim * m_cnt;
            m_idx   = 0;
            if (m_total == 0) begin
                m_run  = 1'b0;
                m_tail = 3;
            end else begin
                m_run  = 1'b1;
                m_tail = -1;
            end
        end else if (m_run) begin
            if (ker_req_i) begin
                m_idx++;
                if (m_idx == m_total) begin
                    m_run  = 1'b0;
                    m_tail = 0;
                end
            end
        end else if (m_tail >= 0) begin
            m_tail++;
            if (m_tail == 4) m_tail = -1;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("ker_ready", ker_ready_o, m_run);
            check("ker_rd_en", ker_rd_en_o, m_run && ker_req_i);
            check("ker_rd_addr", ker_rd_addr_o, m_run ? (m_idx % m_lim) : 0);
            check("layer_last", layer_last_o, m_run && ((m_idx / m_lim) == m_cnt - 1));
            check("busy", busy_o, m_run || (m_tail >= 0 && m_tail <= 2));
            check("done", done_o, m_tail == 3);
        end
    end

    logic [6:0] q_addr[$];
    logic       q_last[$];
    int         done_cyc;

    // Starts a layer and follows it to done_o. mode 0: req held high,
    // 1: req toggles starting high, 2: random req. Cycle 1 is the first read.
    task automatic run_layer(input int lim, input int cnt, input int mode, input string tag);
        int c;
        bit seen_done;
        q_addr.delete();
        q_last.delete();
        done_cyc = -1;
        seen_done = 1'b0;
        c = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        one_exp_ker_addr_limit_i = 7'(lim);
        layer_word_count_i = 16'(cnt);
        ker_req_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) begin
                @(posedge clk_i); #1;
            end
            case (mode)
                0:       ker_req_i = 1'b1;
                1:       ker_req_i = (i % 2 == 0);
                default: ker_req_i = 1'($urandom % 2);
            endcase
            @(negedge clk_i);
            if (c > 0) c++;
            if (ker_rd_en_o) begin
                if (c == 0) c = 1;
                q_addr.push_back(ker_rd_addr_o);
                q_last.push_back(layer_last_o);
            end
            if (done_o) begin
                done_cyc = c;
                seen_done = 1'b1;
                break;
            end
        end
        if (!seen_done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    initial begin
        logic [6:0] exp_addrs [8];
        exp_addrs = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd0, 7'd1, 7'd2, 7'd3};

        // Reset
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        cmp_en = 1'b1;
        @(negedge clk_i);
        check("rst_outputs", {ker_ready_o, ker_rd_en_o, ker_rd_addr_o, layer_last_o, busy_o, done_o}, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // limit=4, count=2, req held high
        run_layer(4, 2, 0, "l4c2");
        check("l4c2_reads", q_addr.size(), 8);
        for (int i = 0; i < 8 && i < q_addr.size(); i++)
            check($sformatf("l4c2_addr%0d", i), q_addr[i], exp_addrs[i]);
        check("l4c2_done_cycle", done_cyc, 12);

        // limit=1, count=3
        run_layer(1, 3, 0, "l1c3");
        check("l1c3_reads", q_addr.size(), 3);
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            check($sformatf("l1c3_addr%0d", i), q_addr[i], 0);
            check($sformatf("l1c3_last%0d", i), q_last[i], (i == 2));
        end

        // limit=3, count=2, req toggling
        run_layer(3, 2, 1, "l3c2t");
        check("l3c2t_reads", q_addr.size(), 6);
        check("l3c2t_done_cycle", done_cyc, 15);

        // limit=0: immediate done, never ready
        @(posedge clk_i); #1;
        start_i = 1'b1; one_exp_ker_addr_limit_i = 7'd0; layer_word_count_i = 16'd3; ker_req_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("l0_done", done_o, 1);
        check("l0_ready", ker_ready_o, 0);
        @(negedge clk_i);
        check("l0_done_clear", done_o, 0);

        // Restart mid-layer at addr=2
        @(posedge clk_i); #1;
        start_i = 1'b1; one_exp_ker_addr_limit_i = 7'd5; layer_word_count_i = 16'd2; ker_req_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(negedge clk_i);
        check("restart_addr_before", ker_rd_addr_o, 2);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("restart_addr_after", ker_rd_addr_o, 0);
        check("restart_ready", ker_ready_o, 1);
        wait_done("restart");

        // Reset mid-run, then a normal layer
        @(posedge clk_i); #1;
        start_i = 1'b1; one_exp_ker_addr_limit_i = 7'd4; layer_word_count_i = 16'd3; ker_req_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("midrst_outputs", {ker_ready_o, ker_rd_en_o, ker_rd_addr_o, layer_last_o, busy_o, done_o}, 0);
        run_layer(2, 2, 0, "after_rst");
        check("after_rst_reads", q_addr.size(), 4);
        check("after_rst_done_cycle", done_cyc, 8);

        // Random layer with random stalls
        run_layer(5, 3, 2, "rand_layer");
        check("rand_layer_reads", q_addr.size(), 15);

        // Randomized traffic: requests, restarts and resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            ker_req_i = 1'($urandom % 4 != 0);
            start_i = ($urandom % 25 == 0);
            one_exp_ker_addr_limit_i = 7'($urandom % 6);
            layer_word_count_i = 16'($urandom % 4);
            rst_n_i = !($urandom % 150 == 0);
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        rst_n_i = 1'b1;
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/expand_kernal_sequencer.md
EXPAND_KERNAL_SEQUENCER -- requirements
Module: expand_kernal_sequencer

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start_i, input, 1 bit: one-cycle pulse that latches the configuration and begins a layer.
REQ-004 SHALL have port one_exp_ker_addr_limit_i, input, 7 bits: kernel words per layer word (wrap limit), sampled on start_i.
REQ-005 SHALL have port layer_word_count_i, input, 16 bits: number of layer words in the layer, sampled on start_i.
REQ-006 SHALL have port ker_req_i, input, 1 bit: kernel fetch request from the expand convolution datapath (3x3 and 1x1 requests are identical).
REQ-007 SHALL have port ker_ready_o, output, 1 bit: the kernel RAMs can accept ker_req_i.
REQ-008 SHALL have port ker_rd_addr_o, output, 7 bits: shared read address for the four 3x3 kernel RAMs and the 1x1 kernel RAM.
REQ-009 SHALL have port ker_rd_en_o, output, 1 bit: kernel RAM read enable.
REQ-010 SHALL have port layer_last_o, output, 1 bit: high while the current address belongs to the final layer word.
REQ-011 SHALL have port busy_o, output, 1 bit: high in RUN and DRAIN.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, RUN, DRAIN, DONE.
REQ-014 On start_i in any state: latch both configuration inputs, set addr=0 and word_cnt=0, and go to RUN; start_i overrides every other event in that cycle.
REQ-015 If start_i has limit==0 or layer_word_count_i==0, SHALL go to DONE instead of RUN (no reads are issued).
REQ-016 ker_ready_o SHALL be 1 only in RUN; otherwise 0.
REQ-017 ker_rd_en_o SHALL equal ker_req_i AND ker_ready_o (combinational).
REQ-018 ker_rd_addr_o SHALL be the registered address; the RAM returns data one cycle after ker_rd_en_o.
REQ-019 Each accepted request (ker_rd_en_o=1) SHALL advance addr by 1; when addr==limit-1, addr SHALL wrap to 0 and word_cnt SHALL increment.
REQ-020 With limit==1, addr SHALL stay 0 and every accepted request SHALL increment word_cnt.
REQ-021 layer_last_o SHALL be (word_cnt==count-1) while in RUN; otherwise 0.
REQ-022 An accepted request that wraps with word_cnt==count-1 SHALL move the FSM to DRAIN; ker_ready_o is 0 from the next cycle.
REQ-023 DRAIN SHALL last exactly 3 cycles (matching the datapath's 2-cycle data/flag pipeline plus 1), then go to DONE.
REQ-024 DONE SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-025 ker_req_i SHALL be ignored outside RUN (no address change, no read).
REQ-026 word_cnt SHALL be 16 bits and addr 7 bits; no overflow is possible for legal configurations.
REQ-027 While ker_req_i is low in RUN, all state SHALL hold (stall).

Reset
REQ-028 While rst_n_i=0 at a clock edge: FSM=IDLE, addr=0, word_cnt=0, latched limit and count=0; outputs ker_ready_o=0, ker_rd_en_o=0, ker_rd_addr_o=0, layer_last_o=0, busy_o=0, done_o=0.
REQ-029 Reset SHALL take priority over start_i, and a mid-layer reset SHALL abort with no done_o pulse.

Verification
REQ-030 limit=4, count=2, ker_req_i held high -> addresses 0,1,2,3,0,1,2,3 over 8 reads; DRAIN 3 cycles; done_o pulse on cycle 12 after the first read.
REQ-031 limit=1, count=3 -> addr stays 0; exactly 3 reads; layer_last_o high on the 3rd read only; then done_o.
REQ-032 limit=3, count=2, ker_req_i toggling 1/0 -> address advances only on high cycles; 6 reads total; no read while ker_ready_o=0.
REQ-033 start_i with limit=0 -> done_o the next cycle; ker_ready_o never asserted.
REQ-034 start_i during RUN at addr=2 -> addr=0 and word_cnt=0 next cycle; the previous layer produces no done_o.
REQ-035 rst_n_i low for 1 cycle mid-RUN -> all outputs 0; IDLE; a later start_i resumes normal operation.
